// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter that shares a 4:1 bit multiplexer between four
//   requesters. One requester owns the mux at a time. An owner is released
//   when it drops its request or after MAX_HOLD consecutive cycles. On
//   release, the mux is handed straight to the next pending requester, with
//   no idle cycle in between.
//
// Handshake: req[i] is a level request. The requester owns the mux while
//   grant[i] is high. It keeps ownership as long as req[i] stays high and
//   the hold limit has not been reached. Dropping req[i] at an edge releases
//   the mux at that same edge.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req[3:0]   in   per-requester level request
//   d[3:0]     in   per-requester data bit
//   grant[3:0] out  registered one-hot grant, zero when idle
//   select[1:0]out  registered mux select (current or last owner)
//   busy       out  registered, high exactly when grant != 0
//   q          out  combinational d[select] while busy, else 0
//   dbg_state  out  FSM state (0 = IDLE, 1 = GRANT)
//   dbg_ptr    out  round-robin search start index
//   dbg_cnt    out  hold counter of the current grant
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       busy,
  output logic       q,
  output logic       dbg_state,
  output logic [1:0] dbg_ptr,
  output logic [3:0] dbg_cnt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] select_q, select_d;
  logic       busy_q, busy_d;

  logic [1:0] win;
  logic       win_found;
  logic [1:0] scan_idx;
  logic       release_now;

  // Winner search: the first requester with req high, in the order
  // ptr, ptr+1, ptr+2, ptr+3. While a grant is active, ptr is owner+1.
  // The owner is therefore scanned last, so a timed-out owner wins again
  // only when nobody else is pending.
  always_comb begin
    win       = ptr_q;
    win_found = 1'b0;
    scan_idx  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!win_found && req[scan_idx]) begin
        win       = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  assign release_now = !req[select_q] || (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 2'd0;
      cnt_q    <= 4'd0;
      grant_q  <= 4'd0;
      select_q <= 2'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    select_d = select_q;
    busy_d   = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d  = ST_GRANT;
          grant_d  = 4'b0001 << win;
          select_d = win;
          busy_d   = 1'b1;
          cnt_d    = 4'd0;
          ptr_d    = win + 2'd1;
        end
      end
      ST_GRANT: begin
        if (!release_now) begin
          cnt_d = cnt_q + 4'd1;
        end else if (win_found) begin
          // Direct handover (or a re-grant to a sole timed-out owner).
          grant_d  = 4'b0001 << win;
          select_d = win;
          busy_d   = 1'b1;
          cnt_d    = 4'd0;
          ptr_d    = win + 2'd1;
        end else begin
          // select keeps the last owner.
          state_d = ST_IDLE;
          grant_d = 4'd0;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic. q only looks at the selected bit, gated by busy, so
  // ungranted data inputs never reach q.
  always_comb begin
    grant     = grant_q;
    select    = select_q;
    busy      = busy_q;
    q         = busy_q & d[select_q];
    dbg_state = state_q;
    dbg_ptr   = ptr_q;
    dbg_cnt   = cnt_q;
  end

endmodule
